// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display. Sits directly upstream of the hex-to-segment
// decoder. Each digit slot is a blanking gap (all digits off) followed by a
// lit phase. The displayed values are snapshotted once per frame, so a change
// of value_i mid-frame never tears the display.
//
// Optional build macro:
//   SEVEN_SEG_SCAN_LZ_BLANK_EN - leading-zero blanking. Digits above the
//                                highest nonzero nibble (or set dp bit) stay
//                                dark during their lit phase. Digit 0 is
//                                always lit. Slot timing is unchanged.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   en_i         scan enable, 0 = display dark
//   value_i      packed nibbles, digit 0 (rightmost) = value_i[3:0]
//   dp_i         decimal point request per digit, 1 = lit
//   hex_o        nibble to the decoder
//   dp_no        active-low decimal point of the current digit
//   dig_no       active-low digit enables, at most one bit low
//   digit_idx_o  index of the current digit
//   frame_o      one-cycle pulse at the start of each frame
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | scan disabled, all digits off
// BLANK | gap before a digit, all off, hex_o/dp_no already show it
// SHOW  | current digit enabled for SLOT_CYCLES-BLANK_CYCLES clocks

module seven_seg_scan #(
  parameter int NUM_DIGITS   = 6,
  parameter int CLK_HZ       = 50000000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic [4*NUM_DIGITS-1:0]       value_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  output logic [3:0]                    hex_o,
  output logic                          dp_no,
  output logic [NUM_DIGITS-1:0]         dig_no,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
  output logic                          frame_o
);

  localparam int SLOT_CYCLES = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int SHOW_CYCLES = SLOT_CYCLES - BLANK_CYCLES;
  localparam int IDX_W       = $clog2(NUM_DIGITS);
  localparam int CNT_W       = $clog2(SLOT_CYCLES + 1);

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  if (SLOT_CYCLES <= BLANK_CYCLES) begin : g_bad_timing
    $error("seven_seg_scan: SLOT_CYCLES must exceed BLANK_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_val_q, snap_val_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [3:0]              hex_q, hex_d;
  logic                    dpn_q, dpn_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    frame_q, frame_d;

  logic                    enter_blank;
  logic                    snap_take;
  logic [IDX_W-1:0]        next_idx;
  logic [NUM_DIGITS-1:0]   lit_mask;

`ifdef SEVEN_SEG_SCAN_LZ_BLANK_EN
  logic [IDX_W-1:0] hi_q, hi_d;
  logic [IDX_W-1:0] hi_new;

  // Highest digit that carries information in the incoming frame.
  always_comb begin
    hi_new = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if ((value_i[4*i +: 4] != 4'h0) || dp_i[i]) begin
        hi_new = IDX_W'(i);
      end
    end
  end

  always_comb begin
    hi_d = hi_q;
    if (snap_take) begin
      hi_d = hi_new;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
    end else begin
      hi_q <= hi_d;
    end
  end

  always_comb begin
    lit_mask = ~(NUM_DIGITS'(1) << idx_q);
    if (idx_q > hi_q) begin
      lit_mask = '1;
    end
  end
`else
  always_comb begin
    lit_mask = ~(NUM_DIGITS'(1) << idx_q);
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    snap_val_d  = snap_val_q;
    snap_dp_d   = snap_dp_q;
    hex_d       = hex_q;
    dpn_d       = dpn_q;
    dig_d       = '1;
    frame_d     = 1'b0;
    enter_blank = 1'b0;
    snap_take   = 1'b0;
    next_idx    = idx_q;

    if (!en_i) begin
      // hex/dp deliberately hold their last values while dark
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          enter_blank = 1'b1;
          next_idx    = '0;
        end
        BLANK: begin
          if (cnt_q == '0) begin
            state_d = SHOW;
            cnt_d   = SHOW_LOAD;
            dig_d   = lit_mask;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == '0) begin
            enter_blank = 1'b1;
            next_idx    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
            dig_d = lit_mask;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (enter_blank) begin
      state_d = BLANK;
      cnt_d   = BLANK_LOAD;
      idx_d   = next_idx;
      // A new frame starts at digit 0: take the snapshot and present digit 0
      // from the fresh values in the same edge.
      if (next_idx == '0) begin
        snap_take  = 1'b1;
        snap_val_d = value_i;
        snap_dp_d  = dp_i;
        frame_d    = 1'b1;
      end
      hex_d = snap_val_d[4*int'(next_idx) +: 4];
      dpn_d = ~snap_dp_d[next_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      snap_val_q <= '0;
      snap_dp_q  <= '0;
      hex_q      <= '0;
      dpn_q      <= 1'b1;
      dig_q      <= '1;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_val_q <= snap_val_d;
      snap_dp_q  <= snap_dp_d;
      hex_q      <= hex_d;
      dpn_q      <= dpn_d;
      dig_q      <= dig_d;
      frame_q    <= frame_d;
    end
  end

  assign hex_o       = hex_q;
  assign dp_no       = dpn_q;
  assign dig_no      = dig_q;
  assign digit_idx_o = idx_q;
  assign frame_o     = frame_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan (4 digits, 6-clock slots, 2 blank).
// Stimulus pushes one expected entry per lit phase; the monitor pops an entry
// whenever a digit turns on and checks index, nibble, dp, enables, lit length
// and that hex/dp stay stable while lit. Frame pulse spacing is also checked.

module tb_seven_seg_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [15:0] value = 16'h1234;
  logic [3:0] dp = 4'b0000;
  logic [3:0] hex_o;
  logic       dp_no;
  logic [3:0] dig_no;
  logic [1:0] idx_o;
  logic       frame_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         idx;
    logic [3:0] hex;
    logic [3:0] dig;
    logic       dpn;
    int         len;
  } exp_t;

  exp_t sb[$];

  seven_seg_scan #(
    .NUM_DIGITS(4), .CLK_HZ(1200), .REFRESH_HZ(50), .BLANK_CYCLES(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .value_i(value), .dp_i(dp),
    .hex_o(hex_o), .dp_no(dp_no), .dig_no(dig_no), .digit_idx_o(idx_o),
    .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic push(input int idx, input logic [3:0] hex, input logic dpn, input int len);
    exp_t e;
    logic [3:0] m;
    m = 4'b0001 << idx;
    e.idx = idx; e.hex = hex; e.dig = ~m; e.dpn = dpn; e.len = len;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk); #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic wait_lit(input logic [1:0] want_idx, input logic [3:0] want_dig, input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(idx_o == want_idx && dig_no == want_dig) && n < max_cyc);
    total++;
    if (!(idx_o == want_idx && dig_no == want_dig)) begin
      bad++;
      $display("FAIL wait_lit: got idx %0d dig %b expected idx %0d dig %b", idx_o, dig_no, want_idx, want_dig);
    end
  endtask

  // Monitor
  initial begin
    exp_t cur;
    bit have_cur = 0;
    bit lit = 0;
    int lit_len = 0;
    logic [3:0] h0;
    logic d0;
    bit unstable = 0;
    int cyc = 0;
    int prev_frame = 0;
    bit prev_valid = 0;
    bit en_low_seen = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!en || !rst_n) en_low_seen = 1;
      if (dig_no != 4'b1111) begin
        if (!lit) begin
          lit = 1; lit_len = 1; h0 = hex_o; d0 = dp_no; unstable = 0;
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_lit: got idx %0d dig %b expected no lit digit", idx_o, dig_no);
            have_cur = 0;
          end else begin
            cur = sb.pop_front();
            have_cur = 1;
            chk("lit_idx", 32'(idx_o), 32'(cur.idx));
            chk("lit_hex", 32'(hex_o), 32'(cur.hex));
            chk("lit_dig", 32'(dig_no), 32'(cur.dig));
            chk("lit_dpn", 32'(dp_no), 32'(cur.dpn));
          end
        end else begin
          lit_len++;
          if (hex_o !== h0 || dp_no !== d0) unstable = 1;
        end
      end else if (lit) begin
        lit = 0;
        if (have_cur) begin
          chk("lit_len", 32'(lit_len), 32'(cur.len));
          chk("lit_stable", 32'(unstable), 32'd0);
        end
        have_cur = 0;
      end
      if (frame_o === 1'b1) begin
        chk("frame_dig", 32'(dig_no), 32'hf);
        chk("frame_idx", 32'(idx_o), 32'd0);
        if (prev_valid && !en_low_seen) chk("frame_period", 32'(cyc - prev_frame), 32'd24);
        prev_frame = cyc; prev_valid = 1; en_low_seen = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dig", 32'(dig_no), 32'hf);
    chk("rst_hex", 32'(hex_o), 32'h0);
    chk("rst_dpn", 32'(dp_no), 32'h1);
    chk("rst_idx", 32'(idx_o), 32'h0);
    chk("rst_frame", 32'(frame_o), 32'h0);

    @(negedge clk); #1;
    rst_n = 1'b1;
    push(0, 4'h4, 1'b1, 4); push(1, 4'h3, 1'b1, 4);
    push(2, 4'h2, 1'b1, 4); push(3, 4'h1, 1'b1, 4);
    en = 1'b1;
    @(negedge clk); #1;
    chk("start_frame", 32'(frame_o), 32'h1);
    chk("start_hex", 32'(hex_o), 32'h4);
    chk("start_dig", 32'(dig_no), 32'hf);

    // Change values while digit 2 is lit: no tearing.
    wait_lit(2'd2, 4'b1011, 100);
    value = 16'hABCD;
    dp = 4'b0100;
    push(0, 4'hD, 1'b1, 4); push(1, 4'hC, 1'b1, 4);
    push(2, 4'hB, 1'b0, 4); push(3, 4'hA, 1'b1, 4);
    push(0, 4'hD, 1'b1, 4); push(1, 4'hC, 1'b1, 1);
    wait_empty(200);

    // Drop enable during SHOW of digit 1.
    en = 1'b0;
    @(negedge clk); #1;
    chk("dis_dig", 32'(dig_no), 32'hf);
    chk("dis_idx", 32'(idx_o), 32'h0);
    chk("dis_hex_hold", 32'(hex_o), 32'hC);
    chk("dis_dpn_hold", 32'(dp_no), 32'h1);
    chk("dis_frame", 32'(frame_o), 32'h0);
    repeat (3) @(negedge clk);
    #1;
    value = 16'h0F07;
    dp = 4'b1000;
    push(0, 4'h7, 1'b1, 4); push(1, 4'h0, 1'b1, 4);
    push(2, 4'hF, 1'b1, 4); push(3, 4'h0, 1'b0, 1);
    en = 1'b1;
    @(negedge clk); #1;
    chk("reen_frame", 32'(frame_o), 32'h1);
    chk("reen_hex", 32'(hex_o), 32'h7);
    chk("reen_idx", 32'(idx_o), 32'h0);
    wait_empty(200);

    // Asynchronous reset while digit 3 is lit, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async_dig", 32'(dig_no), 32'hf);
    chk("async_dpn", 32'(dp_no), 32'h1);
    chk("async_hex", 32'(hex_o), 32'h0);
    chk("async_idx", 32'(idx_o), 32'h0);
    chk("async_frame", 32'(frame_o), 32'h0);
    repeat (2) @(negedge clk);
    #1;

    value = 16'h0050;
    dp = 4'b0000;
    for (int f = 0; f < 2; f++) begin
      push(0, 4'h0, 1'b1, 4); push(1, 4'h5, 1'b1, 4);
`ifndef SEVEN_SEG_SCAN_LZ_BLANK_EN
      push(2, 4'h0, 1'b1, 4); push(3, 4'h0, 1'b1, 4);
`endif
    end
    rst_n = 1'b1;
    wait_empty(200);

    value = 16'h0000;
`ifdef SEVEN_SEG_SCAN_LZ_BLANK_EN
    push(0, 4'h0, 1'b1, 4);
    push(0, 4'h0, 1'b1, 1);
`else
    for (int d = 0; d < 4; d++) push(d, 4'h0, 1'b1, 4);
    for (int d = 0; d < 3; d++) push(d, 4'h0, 1'b1, 4);
    push(3, 4'h0, 1'b1, 1);
`endif
    wait_empty(200);
    en = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("end_dig", 32'(dig_no), 32'hf);
    chk("end_idx", 32'(idx_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
